multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multi-cycle MIPS datapath: a Moore-style FSM, with memory-ready gating, that sequences instruction fetch, decode, execute, memory access and write-back across the shared ALU, register file, unified memory and immediate extender. It decodes the 6-bit opcode and 6-bit funct field and drives every datapath mux select, write enable and ALU control line. It also selects sign or zero extension of the 16-bit immediate, which feeds the 32-bit extender ahead of ALU source B.

## Interface
- No parameters.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock, reset is synchronous and active-high
- opcode  input  6  instr[31:26], sampled from instruction register
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag (beq)
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_en  output  1  PC write enable = pc_write | (branch & zero)
- iord  output  1  0: memory address = PC, 1: ALUOut
- mem_read / mem_write  output  1 each  memory strobes
- ir_write  output  1  load instruction register
- reg_dst  output  1  0: rt, 1: rd
- mem_to_reg  output  1  0: ALUOut, 1: MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0: PC, 1: A
- alu_src_b  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ext_zero  output  1  1: zero-extend immediate (andi/ori), 0: sign-extend
- illegal_op  output  1  one-cycle pulse on unknown opcode or funct

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, IMM_EX, IMM_WB, JUMP.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write and pc_write only when mem_ready=1. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw), 101011 (sw) -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 -> BEQ_EX
  - 001000 (addi), 001100 (andi), 001101 (ori) -> IMM_EX
  - 000010 -> JUMP
  - anything else -> illegal_op=1, next FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, add, ext_zero=0. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - other funct: illegal_op=1, next FETCH with no write-back
  - Next RTYPE_WB.
- RTYPE_WB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, then FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10. Add for addi (ext_zero=0); and/or for andi/ori (ext_zero=1). Next IMM_WB.
- IMM_WB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- Unlisted outputs are 0 in each state. ext_zero holds its IMM_EX value through IMM_WB.
- The opcode is latched internally at DECODE, so IMM_EX/IMM_WB do not depend on later IR changes.

## Timing
- Reset: state=FETCH on the first edge with rst=1. Outputs then take FETCH values: mem_read=1, alu_src_b=01, alu_control=010. All write enables and illegal_op are 0 unless mem_ready=1.
- rst is honoured in any state, mid-instruction or mid-wait. No write enable may assert in the cycle after the reset edge except FETCH's pc_en/ir_write when mem_ready=1.
- Cycles per instruction with mem_ready held 1:
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, illegal 2.
  - Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- pc_en is combinational in BEQ_EX from zero.

## Structure
- Shared package mc_pkg:
  - state enum
  - opcode and funct constants
  - alu_control encodings
  - alu_src_b and pc_src encodings
- Sub-module alu_decoder: maps funct to alu_control (3 bits) and an illegal flag. It is instantiated once and its output is selected in RTYPE_EX. The FSM forces add, sub, and or or directly in the other states.

## Test plan
- Reset then lw (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 only in cycle 5, with mem_to_reg=1 and reg_dst=0.
- beq with zero=1, then with zero=0 -> pc_en=1 in BEQ_EX only for zero=1; pc_src=01; 3 cycles each.
- ori (001101) -> ext_zero=1 and alu_control=001 in IMM_EX; reg_write=1 in IMM_WB; addi instead gives ext_zero=0 and alu_control=010.
- sw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMWR -> FETCH holds with ir_write=0; total 9 cycles; mem_write high for 3 cycles.
- R-type funct 101010 gives alu_control=111. Funct 000111, and separately opcode 111111 -> illegal_op pulses 1 cycle, no reg_write, return to FETCH.
- rst asserted in MEMRD waiting -> next cycle FETCH, mem_write=0, reg_write=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
package mc_pkg;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SRCB_W  = 2;
    localparam int unsigned PCSRC_W = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

    // ALU source B select
    localparam logic [SRCB_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control bundle produced each cycle by the FSM
    typedef struct packed {
        logic                pc_write;
        logic                branch;
        logic                iord;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src_a;
        logic [SRCB_W-1:0]   alu_src_b;
        logic [ALUC_W-1:0]   alu_control;
        logic [PCSRC_W-1:0]  pc_src;
        logic                ext_zero;
        logic                illegal_op;
    } ctrl_t;

    // Dispatch target out of DECODE; unknown opcodes return to FETCH
    function automatic state_t decode_target(input logic [OP_W-1:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW:             s = S_MEMADR;
            OP_RTYPE:                 s = S_RTYPE_EX;
            OP_BEQ:                   s = S_BEQ_EX;
            OP_ADDI, OP_ANDI, OP_ORI: s = S_IMM_EX;
            OP_J:                     s = S_JUMP;
            default:                  s = S_FETCH;
        endcase
        return s;
    endfunction

    // True for every opcode the controller implements
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the R-type funct field onto an ALU operation and flags unknown functs.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [FN_W-1:0]   i_funct,
    output logic [ALUC_W-1:0] o_alu_ctrl_c,
    output logic              o_illegal_c
);

    // Funct lookup; unknown functs fall back to add so the ALU input stays defined
    always_comb begin
        o_alu_ctrl_c = ALU_ADD;
        o_illegal_c  = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_ctrl_c = ALU_ADD;
            FN_SUB:  o_alu_ctrl_c = ALU_SUB;
            FN_AND:  o_alu_ctrl_c = ALU_AND;
            FN_OR:   o_alu_ctrl_c = ALU_OR;
            FN_SLT:  o_alu_ctrl_c = ALU_SLT;
            default: o_illegal_c  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory-ready gating.
module multicycle_control
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FN_W-1:0]    funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [SRCB_W-1:0]  alu_src_b,
    output logic [ALUC_W-1:0]  alu_control,
    output logic [PCSRC_W-1:0] pc_src,
    output logic               ext_zero,
    output logic               illegal_op
);

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_opcode;
    ctrl_t             w_ctrl;
    logic [ALUC_W-1:0] w_fn_alu;
    logic              w_fn_illegal;

    alu_decoder u_alu_decoder (
        .i_funct      (funct),
        .o_alu_ctrl_c (w_fn_alu),
        .o_illegal_c  (w_fn_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode captured in DECODE so later states ignore IR changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode <= '0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.iord        = 1'b0;
                w_ctrl.alu_src_a   = 1'b0;
                w_ctrl.alu_src_b   = SRCB_FOUR;
                w_ctrl.alu_control = ALU_ADD;
                w_ctrl.pc_src      = PCSRC_ALU;
                w_ctrl.ir_write    = mem_ready;
                w_ctrl.pc_write    = mem_ready;
                w_next             = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a   = 1'b0;
                w_ctrl.alu_src_b   = SRCB_IMM_SH;
                w_ctrl.alu_control = ALU_ADD;
                w_ctrl.illegal_op  = ~op_is_legal(opcode);
                w_next             = decode_target(opcode);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a   = 1'b1;
                w_ctrl.alu_src_b   = SRCB_IMM;
                w_ctrl.alu_control = ALU_ADD;
                w_ctrl.ext_zero    = 1'b0;
                w_next             = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_next          = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_ctrl.reg_dst    = 1'b0;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEMWR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_next           = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPE_EX: begin
                w_ctrl.alu_src_a   = 1'b1;
                w_ctrl.alu_src_b   = SRCB_B;
                w_ctrl.alu_control = w_fn_alu;
                w_ctrl.illegal_op  = w_fn_illegal;
                w_next             = w_fn_illegal ? S_FETCH : S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
                w_ctrl.reg_write  = 1'b1;
                w_next            = S_FETCH;
            end
            S_BEQ_EX: begin
                w_ctrl.alu_src_a   = 1'b1;
                w_ctrl.alu_src_b   = SRCB_B;
                w_ctrl.alu_control = ALU_SUB;
                w_ctrl.branch      = 1'b1;
                w_ctrl.pc_src      = PCSRC_ALUOUT;
                w_next             = S_FETCH;
            end
            S_IMM_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                case (r_opcode)
                    OP_ANDI: begin
                        w_ctrl.alu_control = ALU_AND;
                        w_ctrl.ext_zero    = 1'b1;
                    end
                    OP_ORI: begin
                        w_ctrl.alu_control = ALU_OR;
                        w_ctrl.ext_zero    = 1'b1;
                    end
                    default: begin
                        w_ctrl.alu_control = ALU_ADD;
                        w_ctrl.ext_zero    = 1'b0;
                    end
                endcase
                w_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                w_ctrl.reg_dst    = 1'b0;
                w_ctrl.mem_to_reg = 1'b0;
                w_ctrl.reg_write  = 1'b1;
                // Extender mode stays put while the result is written back
                w_ctrl.ext_zero   = (r_opcode == OP_ANDI) || (r_opcode == OP_ORI);
                w_next            = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_src   = PCSRC_JUMP;
                w_ctrl.pc_write = 1'b1;
                w_next          = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Control bundle to ports; branch qualifies the PC enable with the ALU zero flag
    always_comb begin
        pc_en       = w_ctrl.pc_write | (w_ctrl.branch & zero);
        iord        = w_ctrl.iord;
        mem_read    = w_ctrl.mem_read;
        mem_write   = w_ctrl.mem_write;
        ir_write    = w_ctrl.ir_write;
        reg_dst     = w_ctrl.reg_dst;
        mem_to_reg  = w_ctrl.mem_to_reg;
        reg_write   = w_ctrl.reg_write;
        alu_src_a   = w_ctrl.alu_src_a;
        alu_src_b   = w_ctrl.alu_src_b;
        alu_control = w_ctrl.alu_control;
        pc_src      = w_ctrl.pc_src;
        ext_zero    = w_ctrl.ext_zero;
        illegal_op  = w_ctrl.illegal_op;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver queues per-cycle expected controls, monitor checks.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       illegal_op;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    outs_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .ext_zero    (ext_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    // Expected control vectors per state
    function automatic outs_t e_fetch(input logic mr);
        outs_t e = '0;
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        e.ir_write = mr; e.pc_en = mr;
        return e;
    endfunction
    function automatic outs_t e_decode(input logic ill);
        outs_t e = '0;
        e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal_op = ill;
        return e;
    endfunction
    function automatic outs_t e_memadr();
        outs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
        return e;
    endfunction
    function automatic outs_t e_memrd();
        outs_t e = '0;
        e.iord = 1'b1; e.mem_read = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_memwb();
        outs_t e = '0;
        e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_memwr();
        outs_t e = '0;
        e.iord = 1'b1; e.mem_write = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_rex(input logic [2:0] alu, input logic ill);
        outs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_control = alu; e.illegal_op = ill;
        return e;
    endfunction
    function automatic outs_t e_rwb();
        outs_t e = '0;
        e.reg_dst = 1'b1; e.reg_write = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_beq(input logic z);
        outs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
        return e;
    endfunction
    function automatic outs_t e_iex(input logic [2:0] alu, input logic ez);
        outs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = alu; e.ext_zero = ez;
        return e;
    endfunction
    function automatic outs_t e_iwb(input logic ez);
        outs_t e = '0;
        e.reg_write = 1'b1; e.ext_zero = ez;
        return e;
    endfunction
    function automatic outs_t e_jump();
        outs_t e = '0;
        e.pc_src = 2'b10; e.pc_en = 1'b1;
        return e;
    endfunction

    // One cycle of stimulus: set inputs, queue the expectation, advance
    task automatic cyc(input string nm, input outs_t e, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e;
            outs_t a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_control, pc_src, ext_zero, illegal_op};
            total = total + 1;
            if (a !== e) begin
                bad = bad + 1;
                $display("FAIL %s: got=%05h expected=%05h", nm, a, e);
            end
        end
    end

    initial begin
        // One reset edge
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw, no waits: 5 cycles
        opcode = 6'b100011;
        cyc("lw_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("lw_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("lw_memadr", e_memadr(), 1'b1, 1'b0);
        cyc("lw_memrd",  e_memrd(), 1'b1, 1'b0);
        cyc("lw_memwb",  e_memwb(), 1'b1, 1'b0);

        // beq taken, then not taken
        opcode = 6'b000100;
        cyc("beq1_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("beq1_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("beq1_ex",     e_beq(1'b1), 1'b1, 1'b1);
        cyc("beq0_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("beq0_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("beq0_ex",     e_beq(1'b0), 1'b1, 1'b0);

        // ori; IR changes during IMM_EX must not disturb the latched opcode
        opcode = 6'b001101;
        cyc("ori_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("ori_decode", e_decode(1'b0), 1'b1, 1'b0);
        opcode = 6'b000000;
        cyc("ori_ex",     e_iex(3'b001, 1'b1), 1'b1, 1'b0);
        cyc("ori_wb",     e_iwb(1'b1), 1'b1, 1'b0);

        // addi and andi
        opcode = 6'b001000;
        cyc("addi_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("addi_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("addi_ex",     e_iex(3'b010, 1'b0), 1'b1, 1'b0);
        cyc("addi_wb",     e_iwb(1'b0), 1'b1, 1'b0);
        opcode = 6'b001100;
        cyc("andi_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("andi_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("andi_ex",     e_iex(3'b000, 1'b1), 1'b1, 1'b0);
        cyc("andi_wb",     e_iwb(1'b1), 1'b1, 1'b0);

        // sw with 3 fetch waits and 2 write waits: 9 cycles; mem_ready low in DECODE/MEMADR is ignored
        opcode = 6'b101011;
        for (int i = 0; i < 3; i++) cyc("sw_fetch_wait", e_fetch(1'b0), 1'b0, 1'b0);
        cyc("sw_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("sw_decode", e_decode(1'b0), 1'b0, 1'b0);
        cyc("sw_memadr", e_memadr(), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("sw_memwr_wait", e_memwr(), 1'b0, 1'b0);
        cyc("sw_memwr",  e_memwr(), 1'b1, 1'b0);

        // R-type slt and sub
        opcode = 6'b000000;
        funct  = 6'b101010;
        cyc("slt_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("slt_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("slt_ex",     e_rex(3'b111, 1'b0), 1'b1, 1'b0);
        cyc("slt_wb",     e_rwb(), 1'b1, 1'b0);
        funct  = 6'b100010;
        cyc("sub_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("sub_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("sub_ex",     e_rex(3'b110, 1'b0), 1'b1, 1'b0);
        cyc("sub_wb",     e_rwb(), 1'b1, 1'b0);

        // Illegal funct: pulse in RTYPE_EX, no write-back
        funct  = 6'b000111;
        cyc("badfn_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("badfn_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("badfn_ex",     e_rex(3'b010, 1'b1), 1'b1, 1'b0);

        // Illegal opcode: pulse in DECODE, back to FETCH
        opcode = 6'b111111;
        cyc("badop_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("badop_decode", e_decode(1'b1), 1'b1, 1'b0);

        // Jump
        opcode = 6'b000010;
        cyc("j_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("j_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("j_jump",   e_jump(), 1'b1, 1'b0);

        // Reset while waiting in MEMRD
        opcode = 6'b100011;
        cyc("rst_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
        cyc("rst_decode", e_decode(1'b0), 1'b1, 1'b0);
        cyc("rst_memadr", e_memadr(), 1'b1, 1'b0);
        cyc("rst_memrd_wait", e_memrd(), 1'b0, 1'b0);
        rst = 1'b1;
        cyc("rst_memrd_edge", e_memrd(), 1'b0, 1'b0);
        rst = 1'b0;
        cyc("rst_after_fetch", e_fetch(1'b0), 1'b0, 1'b0);
        cyc("rst_after_fetch_rdy", e_fetch(1'b1), 1'b1, 1'b0);
        cyc("rst_after_decode", e_decode(1'b0), 1'b1, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
